dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single DRAM block port between two cache requesters: req0 = I-cache, req1 = D-cache.
//  Round-robin grants whole block transactions, one at a time, and drives the DRAM op/valid/store lines.
//  Counts the fixed DRAM latency and the beat train, then steers each beat to/from the granted requester.
//  Sits between the cache controllers and DRAM at the top of the memory subsystem.
// PARAMETERS
//  DATA_WIDTH  8   width of one beat (must match DRAM DATA_WIDTH)
//  BLOCK_SIZE  32  beats per transaction (must match DRAM BLOCK_SIZE); 1..128
//  LATENCY     4   cycles from issue to first beat (must match DRAM LATENCY); 1..127
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset; asynchronous, active-low
//  req0_vld     in   1   I-cache requests a transaction; hold until req0_rdy
//  req0_rdy     out  1   1-cycle grant pulse; op/addr sampled this cycle
//  req0_is_rd   in   1   1 = block read, 0 = block write
//  req0_addr    in   32  block base address, passed unmodified
//  req0_wdata   in   DW  write beat, sampled while req0_beat=1
//  req0_rdata   out  DW  read beat, valid while req0_beat=1
//  req0_beat    out  1   beat strobe for req0's active transaction
//  req0_done    out  1   pulse with final beat of req0's transaction
//  req1_*       --   --  identical set for D-cache
//  beat_idx     out  8   index of current beat, 0..BLOCK_SIZE-1
//  m_vld        out  1   to DRAM cache_vld: 1-cycle issue pulse
//  m_is_rd      out  1   to DRAM dram_is_rd
//  m_addr       out  32  to DRAM dram_op_address
//  m_wdata      out  DW  to DRAM dram_store (granted requester's wdata)
//  m_rdata      in   DW  from DRAM dram_load
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset values: all outputs 0; state IDLE; counters 0; last_grant = 1, so req0 wins first.
//  States:
//   IDLE  - if any vld: grant (rdy=1) -> ISSUE; latch sel, is_rd, addr
//   ISSUE - m_vld=1 one cycle with latched is_rd/addr; load timer=LATENCY-1 -> WAIT
//   WAIT  - decrement timer; at 0 load beat counter=0 -> XFER
//   XFER  - beat strobe to sel each cycle, beat_idx=counter; at BLOCK_SIZE-1 pulse done -> IDLE
//  Timing: grant at T, issue at T+1, beats T+LATENCY+2 .. T+LATENCY+BLOCK_SIZE+1.
//   Next grant possible at T+LATENCY+BLOCK_SIZE+2.
//  Arbitration:
//   - Both vld in IDLE: grant the requester != last_grant; last_grant updates on grant.
//   - A single vld is granted regardless of last_grant.
//   - A vld raised during ISSUE/WAIT/XFER waits; it is never dropped.
//  m_is_rd/m_addr hold latched values from ISSUE through XFER; 0 in IDLE.
//  Write steering: m_wdata = sel ? req1_wdata : req0_wdata during XFER, else 0 (combinational).
//  Read steering:
//   - reqN_rdata = m_rdata while reqN_beat, else 0.
//   - reqN_beat/done never assert for the non-selected requester.
//  Widths: counters 8-bit unsigned; no wrap, because parameter limits keep LATENCY+BLOCK_SIZE <= 255.
//  Reset mid-transaction: return to IDLE immediately; no done pulse. DRAM must be reset in the same window.
//  LATENCY=1: WAIT lasts one cycle (timer loads 0).
// STRUCTURE
//  Package dram_arb_pkg: state enum {IDLE,ISSUE,WAIT,XFER}, CNT_W=8, default LATENCY/BLOCK_SIZE.
//  Sub-module dram_arb_timer: loadable down-counter plus up beat counter, with zero/last flags.
//  Arbiter FSM and steering muxes stay in this module.
// TESTING
//  1 Reset: rst=0 with vld high -> all outputs 0. rst=1 + req0_vld -> req0_rdy next edge.
//  2 req0 read addr 0x40 -> m_vld 1 cycle, m_addr=0x40, m_is_rd=1.
//    Exactly 32 req0_beat at T+6..T+37; req0_done at T+37; req1_beat never.
//  3 req1 write addr 0x20, wdata=beat_idx+8'hA0 -> m_wdata=A0..BF on beats 0..31, matched in DRAM.
//  4 Both vld held continuously -> grants alternate req0, req1, req0.
//    Grant spacing exactly LATENCY+BLOCK_SIZE+2 = 38 cycles.
//  5 req1_vld raised mid-XFER of req0 -> req1_rdy in first IDLE cycle after req0_done.
//  6 rst=0 at beat 10 -> outputs 0 asynchronously; no done.
//    After release, req1 read completes with 32 beats.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the two-requester DRAM block-port arbiter.
// Counters are 8 bits; parameter limits keep LATENCY+BLOCK_SIZE <= 255.
package dram_arb_pkg;

    localparam int CNT_W          = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BLOCK_SIZE = 32;
    localparam int DEF_LATENCY    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        XFER
    } state_t;

endpackage

// File: rtl/dram_arb_timer.sv
// Latency down-counter and beat up-counter for one block transaction.
// The latency counter holds at zero; the beat counter holds at its last value.
module dram_arb_timer
    import dram_arb_pkg::*;
#(
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic             clr,
    input  logic             inc,
    output logic             zero,
    output logic [CNT_W-1:0] beat,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] LAST_IX = CNT_W'(BLOCK_SIZE - 1);

    logic [CNT_W-1:0] tmr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr  <= '0;
            beat <= '0;
        end else begin
            if (load)
                tmr <= LAT_M1;
            else if (dec && tmr != '0)
                tmr <= tmr - 1'b1;
            if (clr)
                beat <= '0;
            else if (inc)
                beat <= beat + 1'b1;
        end
    end

    assign zero = (tmr == '0);
    assign last = (beat == LAST_IX);

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the DRAM block port between I-cache (req0)
// and D-cache (req1); one whole block transaction at a time.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_vld,
    output logic                  req0_rdy,
    input  logic                  req0_is_rd,
    input  logic [31:0]           req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_beat,
    output logic                  req0_done,
    input  logic                  req1_vld,
    output logic                  req1_rdy,
    input  logic                  req1_is_rd,
    input  logic [31:0]           req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_beat,
    output logic                  req1_done,
    output logic [CNT_W-1:0]      beat_idx,
    output logic                  m_vld,
    output logic                  m_is_rd,
    output logic [31:0]           m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    state_t           state;
    logic             sel;
    logic             last_grant;
    logic             lat_rd;
    logic [31:0]      lat_addr;
    logic             m_vld_r;
    logic             idle;
    logic             xfer;
    logic             any_vld;
    logic             gnt_sel;
    logic             tmr_load;
    logic             tmr_dec;
    logic             beat_clr;
    logic             beat_inc;
    logic             tmr_zero;
    logic             beat_last;
    logic [CNT_W-1:0] beat_cnt;

    assign idle    = (state == IDLE);
    assign xfer    = (state == XFER);
    assign any_vld = req0_vld | req1_vld;
    // Contention goes to whoever did not win last; a lone requester always wins.
    assign gnt_sel = (req0_vld & req1_vld) ? ~last_grant : req1_vld;

    // Grant is combinational in IDLE; gating with rst keeps it low in reset.
    assign req0_rdy = rst & idle & req0_vld & ~gnt_sel;
    assign req1_rdy = rst & idle & gnt_sel;

    assign tmr_load = (state == ISSUE);
    assign tmr_dec  = (state == WAIT);
    assign beat_clr = (state == WAIT) & tmr_zero;
    assign beat_inc = xfer & ~beat_last;

    dram_arb_timer #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .LATENCY   (LATENCY)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(tmr_load),
        .dec (tmr_dec),
        .clr (beat_clr),
        .inc (beat_inc),
        .zero(tmr_zero),
        .beat(beat_cnt),
        .last(beat_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            lat_rd     <= 1'b0;
            lat_addr   <= '0;
            m_vld_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_vld) begin
                        sel        <= gnt_sel;
                        last_grant <= gnt_sel;
                        lat_rd     <= gnt_sel ? req1_is_rd : req0_is_rd;
                        lat_addr   <= gnt_sel ? req1_addr : req0_addr;
                        m_vld_r    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_vld_r <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (tmr_zero)
                        state <= XFER;
                end
                XFER: begin
                    if (beat_last) begin
                        lat_rd   <= 1'b0;
                        lat_addr <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_vld   = m_vld_r;
    assign m_is_rd = lat_rd;
    assign m_addr  = lat_addr;

    assign req0_beat = xfer & ~sel;
    assign req1_beat = xfer & sel;
    assign req0_done = req0_beat & beat_last;
    assign req1_done = req1_beat & beat_last;
    assign beat_idx  = xfer ? beat_cnt : '0;

    assign req0_rdata = req0_beat ? m_rdata : '0;
    assign req1_rdata = req1_beat ? m_rdata : '0;
    assign m_wdata    = xfer ? (sel ? req1_wdata : req0_wdata) : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter against a transaction-timeline model.
// Each grant at cycle T predicts issue at T+1 and beats T+L+2..T+L+B+1.
module tb_dram_arbiter;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int B  = 32;

    logic          clk;
    logic          rst;
    logic          req0_vld, req1_vld;
    logic          req0_rdy, req1_rdy;
    logic          req0_is_rd, req1_is_rd;
    logic [31:0]   req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          req0_beat, req1_beat;
    logic          req0_done, req1_done;
    logic [7:0]    beat_idx;
    logic          m_vld, m_is_rd;
    logic [31:0]   m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    dram_arbiter #(
        .DATA_WIDTH(DW),
        .BLOCK_SIZE(B),
        .LATENCY   (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_vld  (req0_vld),
        .req0_rdy  (req0_rdy),
        .req0_is_rd(req0_is_rd),
        .req0_addr (req0_addr),
        .req0_wdata(req0_wdata),
        .req0_rdata(req0_rdata),
        .req0_beat (req0_beat),
        .req0_done (req0_done),
        .req1_vld  (req1_vld),
        .req1_rdy  (req1_rdy),
        .req1_is_rd(req1_is_rd),
        .req1_addr (req1_addr),
        .req1_wdata(req1_wdata),
        .req1_rdata(req1_rdata),
        .req1_beat (req1_beat),
        .req1_done (req1_done),
        .beat_idx  (beat_idx),
        .m_vld     (m_vld),
        .m_is_rd   (m_is_rd),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Requester intent and model state
    bit          p0, p1, rd0, rd1;
    logic [31:0] a0, a1;
    bit          last_g;
    int          free_at;
    int          cur_t;
    bit          cur_sel, cur_rd;
    logic [31:0] cur_addr;
    bit          rand_on, in_rst, rel_rst, mid_arm, mid_hit;
    int          n_grant0, n_grant1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        last_g  = 1'b1;
        free_at = 0;
        cur_t   = -1000;
    endtask

    task automatic drive();
        req0_vld   = p0;
        req0_is_rd = rd0;
        req0_addr  = a0;
        req1_vld   = p1;
        req1_is_rd = rd1;
        req1_addr  = a1;
        req0_wdata = DW'($urandom);
        req1_wdata = DW'($urandom);
        m_rdata    = DW'($urandom);
    endtask

    task automatic check_zero();
        chk("rst_rdy0", req0_rdy, 0);
        chk("rst_rdy1", req1_rdy, 0);
        chk("rst_mvld", m_vld, 0);
        chk("rst_mrd", m_is_rd, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_beat0", req0_beat, 0);
        chk("rst_beat1", req1_beat, 0);
        chk("rst_done0", req0_done, 0);
        chk("rst_done1", req1_done, 0);
        chk("rst_idx", beat_idx, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);
        chk("rst_wdata", m_wdata, 0);
    endtask

    task automatic evaluate();
        bit g, w, act, xf, b0, b1;
        int idx;
        g   = (cyc >= free_at) && (p0 || p1);
        w   = (p0 && p1) ? !last_g : p1;
        act = (cyc >= cur_t + 1) && (cyc <= cur_t + L + B + 1);
        xf  = (cyc >= cur_t + L + 2) && (cyc <= cur_t + L + B + 1);
        idx = xf ? cyc - (cur_t + L + 2) : 0;
        b0  = xf && !cur_sel;
        b1  = xf && cur_sel;
        chk("rdy0", req0_rdy, 32'(g && !w));
        chk("rdy1", req1_rdy, 32'(g && w));
        chk("m_vld", m_vld, 32'(cyc == cur_t + 1));
        chk("m_is_rd", m_is_rd, 32'(act && cur_rd));
        chk("m_addr", m_addr, act ? cur_addr : 32'd0);
        chk("beat0", req0_beat, 32'(b0));
        chk("beat1", req1_beat, 32'(b1));
        chk("done0", req0_done, 32'(b0 && idx == B - 1));
        chk("done1", req1_done, 32'(b1 && idx == B - 1));
        chk("beat_idx", beat_idx, 32'(idx));
        chk("rdata0", req0_rdata, b0 ? 32'(m_rdata) : 32'd0);
        chk("rdata1", req1_rdata, b1 ? 32'(m_rdata) : 32'd0);
        chk("m_wdata", m_wdata,
            xf ? 32'(cur_sel ? req1_wdata : req0_wdata) : 32'd0);
        if (g) begin
            cur_t    = cyc;
            cur_sel  = w;
            cur_rd   = w ? rd1 : rd0;
            cur_addr = w ? a1 : a0;
            last_g   = w;
            free_at  = cyc + L + B + 2;
            if (w) begin
                p1 = 0;
                n_grant1++;
            end else begin
                p0 = 0;
                n_grant0++;
            end
        end
        if (rand_on && !p0 && $urandom_range(7) == 0) begin
            p0  = 1;
            rd0 = 1'($urandom);
            a0  = $urandom;
        end
        if (rand_on && !p1 && $urandom_range(7) == 0) begin
            p1  = 1;
            rd1 = 1'($urandom);
            a1  = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (rel_rst) begin
            rst     = 1'b1;
            in_rst  = 0;
            rel_rst = 0;
        end
        drive();
        if (mid_arm && !in_rst && cyc == cur_t + L + 2 + 10) begin
            #1 rst = 1'b0;
            in_rst  = 1;
            mid_arm = 0;
            mid_hit = 1;
            p0      = 0;
            p1      = 0;
            rand_on = 0;
            model_reset();
        end
        @(negedge clk);
        if (in_rst)
            check_zero();
        else
            evaluate();
    endtask

    initial begin
        rst      = 1'b0;
        in_rst   = 1;
        rel_rst  = 0;
        mid_arm  = 0;
        mid_hit  = 0;
        rand_on  = 0;
        n_grant0 = 0;
        n_grant1 = 0;
        model_reset();
        p0  = 1;
        rd0 = 1;
        a0  = 32'h40;
        p1  = 1;
        rd1 = 0;
        a1  = 32'h20;
        drive();
        repeat (3) step();
        // Release with both requesting: req0 must win first.
        rel_rst = 1;
        step();
        repeat (120) begin
            if (!p0 && !p1) begin
                p0  = 1;
                rd0 = 1'($urandom);
                a0  = $urandom;
                p1  = 1;
                rd1 = 1'($urandom);
                a1  = $urandom;
            end
            step();
        end
        chk("grants_alt", 32'(n_grant0 - n_grant1) <= 1, 1);
        rand_on = 1;
        repeat (1500) step();
        p0 = 1;
        rd0 = 1;
        a0 = $urandom;
        mid_arm = 1;
        for (int i = 0; i < 300 && mid_arm; i++)
            step();
        chk("mid_rst_hit", 32'(mid_hit), 1);
        repeat (2) step();
        p1  = 1;
        rd1 = 1;
        a1  = 32'h80;
        rel_rst = 1;
        repeat (60) step();
        chk("post_rst_grant", 32'(cur_sel && cur_t > 0), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
